activation_unit: RTL and testbench
==================================

Name: activation_unit

Overview:
Parametrised successor to the single-mode ReLU layer. On `start` it sweeps a full feature map and applies one of four runtime-selectable activations: pass-through, ReLU, leaky ReLU or clipped ReLU. It processes LANES adjacent columns per cycle and reports a negative-input count as a sparsity statistic. It sits between a conv/pool stage and the next layer, with the same start/done handshake.

Parameters:
DATA_WIDTH, 16, signed fixed-point width of input and output elements
FRAC_BITS, 7, fractional bits; a clamp value of 6.0 encodes as 6<<FRAC_BITS
CHANNELS, 8, number of channels
IMG_SIZE, 28, feature-map height and width
LANES, 4, columns processed per cycle; IMG_SIZE % LANES must be 0 (elaboration-time assertion)
LEAKY_SHIFT, 3, leaky slope is 2^-LEAKY_SHIFT

Ports:
clk  in  1  clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
mode  in  2  0 PASS, 1 RELU, 2 LEAKY, 3 CLIP; latched when start is accepted
clamp_max  in  DATA_WIDTH  signed CLIP ceiling; latched when start is accepted
in_feature  in  DATA_WIDTH x [CHANNELS][IMG_SIZE][IMG_SIZE]  signed input map; must be held stable while busy
out_feature  out  DATA_WIDTH x [CHANNELS][IMG_SIZE][IMG_SIZE]  signed result map, registered
busy  out  1  high from start acceptance until the done cycle
done  out  1  one-cycle completion pulse
neg_count  out  $clog2(CHANNELS*IMG_SIZE*IMG_SIZE+1)  number of elements with sign bit set in the last run

Behaviour:
- Reset values: state IDLE, busy 0, done 0, neg_count 0, indices 0.
- out_feature is not reset. It holds prior contents and is valid only after done.
- Definitions: N = CHANNELS*IMG_SIZE*(IMG_SIZE/LANES). Start is accepted at edge E.
- FSM states IDLE, RUN and FINISH:
  - IDLE: done<=0. If start, latch mode and clamp_max, clear c/r/q and neg_count, set busy<=1, go to RUN.
  - RUN: at edges E+1..E+N, write lanes q..q+LANES-1 of row r, channel c. Traversal order is column (step LANES), then row, then channel. After the last group of the last channel, go to FINISH.
  - FINISH: at edge E+N+1, done<=1, busy<=0, go to IDLE. done falls at E+N+2.
- start while busy is ignored with no effect. start coincident with done high (state is IDLE) is accepted.
- Per-element function for input v:
  - PASS: v.
  - RELU: v<0 ? 0 : v.
  - LEAKY: v<0 ? (v >>> LEAKY_SHIFT) : v. The shift is arithmetic and floors toward minus infinity, so there is no overflow.
  - CLIP: min(max(v,0), clamp_max). If clamp_max < 0, the ceiling is treated as 0 and every output is 0.
- neg_count adds popcount(lane sign bits) each RUN cycle, regardless of mode. It holds after done until the next accepted start.
- Reset mid-operation returns to IDLE on the next edge. busy, done and neg_count go to 0. Partially written out_feature is retained; no done pulse is produced.
- All comparisons are signed at DATA_WIDTH. There is no width growth; outputs are exactly DATA_WIDTH.

Decomposition:
- Package act_pkg holds:
  - act_mode_t enum (ACT_PASS, ACT_RELU, ACT_LEAKY, ACT_CLIP, 2 bits)
  - act_state_t enum (IDLE, RUN, FINISH)
- Sub-module act_lane is purely combinational: one element in, mode, clamp and LEAKY_SHIFT in, one element out, plus an is_neg flag. It is instantiated LANES times via generate.
- The FSM, counters, latches and neg_count accumulator stay in activation_unit.

Test Plan:
Use CHANNELS=2, IMG_SIZE=4, LANES=2, DATA_WIDTH=16, FRAC_BITS=7, LEAKY_SHIFT=3 (N=16).
1. RELU with inputs {-5, 0, 7, -32768} tiled -> outputs {0, 0, 7, 0}; busy high 17 cycles; done high exactly at edge E+17 for one cycle; neg_count=16.
2. LEAKY with inputs {-40, -3, -32768, 100} tiled -> outputs {-5, -1, -4096, 100}; neg_count=24.
3. CLIP with clamp_max=768 (6.0) and inputs {1000, 768, 500, -5} -> outputs {768, 768, 500, 0}. Repeat with clamp_max=-1 -> all outputs 0.
4. PASS with a ramp input -> out_feature equals in_feature bit-exactly. Also toggle mode and clamp_max mid-run -> no effect, since the latched values are used.
5. Pulse start at RUN cycle 5 -> ignored; done still at E+17. Pulse start in the done cycle -> new run begins; busy re-asserts at the next edge.
6. Assert reset at RUN cycle 8 -> next edge gives busy=0, done=0, neg_count=0; no done pulse. A subsequent start completes normally with correct results.

Source files
------------

// File: rtl/act_pkg.sv
// Shared types for the activation unit.
//   act_mode_t  : runtime-selectable activation function (2 bits)
//   act_state_t : sweep controller states
//   idx_w()     : counter width for an index ranging over 0..n-1 (min 1 bit)
package act_pkg;

    typedef enum logic [1:0] {
        ACT_PASS  = 2'd0,
        ACT_RELU  = 2'd1,
        ACT_LEAKY = 2'd2,
        ACT_CLIP  = 2'd3
    } act_mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } act_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/act_lane.sv
// One activation lane, purely combinational.
//   din_i    : signed input element
//   mode_i   : activation select
//   clamp_i  : signed CLIP ceiling (negative ceiling behaves as 0)
//   dout_o   : signed result, same width as input
//   is_neg_o : sign bit of the input, for the sparsity count
module act_lane
    import act_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int LEAKY_SHIFT = 3
) (
    input  logic signed [DATA_WIDTH-1:0] din_i,
    input  act_mode_t                    mode_i,
    input  logic signed [DATA_WIDTH-1:0] clamp_i,
    output logic signed [DATA_WIDTH-1:0] dout_o,
    output logic                         is_neg_o
);

    logic signed [DATA_WIDTH-1:0] relu;
    logic signed [DATA_WIDTH-1:0] ceil;

    always_comb begin
        relu     = din_i[DATA_WIDTH-1] ? '0 : din_i;
        ceil     = clamp_i[DATA_WIDTH-1] ? '0 : clamp_i;
        is_neg_o = din_i[DATA_WIDTH-1];
        dout_o   = din_i;
        case (mode_i)
            ACT_PASS:  dout_o = din_i;
            ACT_RELU:  dout_o = relu;
            // Arithmetic shift floors toward -inf; magnitude only shrinks.
            ACT_LEAKY: dout_o = din_i[DATA_WIDTH-1] ? (din_i >>> LEAKY_SHIFT) : din_i;
            ACT_CLIP:  dout_o = (relu > ceil) ? ceil : relu;
            default:   dout_o = din_i;
        endcase
    end

endmodule

// File: rtl/activation_unit.sv
// Feature-map activation engine. On start, sweeps every element
// (column groups of LANES, then rows, then channels), applying the latched
// activation mode, and counts negative inputs.
//   clk, reset    : clock, synchronous active-high reset
//   start         : run request, honoured only in IDLE
//   mode          : activation select, latched on accepted start
//   clamp_max     : CLIP ceiling, latched on accepted start
//   in_feature    : input map, held stable while busy
//   out_feature   : registered result map (not reset)
//   busy, done    : run in progress / one-cycle completion pulse
//   neg_count     : negative elements seen in the last run
module activation_unit
    import act_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BITS   = 7,
    parameter int CHANNELS    = 8,
    parameter int IMG_SIZE    = 28,
    parameter int LANES       = 4,
    parameter int LEAKY_SHIFT = 3
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic                                                   start,
    input  logic [1:0]                                             mode,
    input  logic signed [DATA_WIDTH-1:0]                           clamp_max,
    input  logic [CHANNELS-1:0][IMG_SIZE-1:0][IMG_SIZE-1:0][DATA_WIDTH-1:0] in_feature,
    output logic [CHANNELS-1:0][IMG_SIZE-1:0][IMG_SIZE-1:0][DATA_WIDTH-1:0] out_feature,
    output logic                                                   busy,
    output logic                                                   done,
    output logic [$clog2(CHANNELS*IMG_SIZE*IMG_SIZE+1)-1:0]        neg_count
);

    localparam int CW = idx_w(CHANNELS);
    localparam int QW = idx_w(IMG_SIZE);
    localparam int NW = $clog2(CHANNELS*IMG_SIZE*IMG_SIZE+1);

    localparam logic [QW-1:0] Q_LAST = QW'(IMG_SIZE - LANES);
    localparam logic [QW-1:0] Q_STEP = QW'(LANES);
    localparam logic [QW-1:0] R_LAST = QW'(IMG_SIZE - 1);
    localparam logic [CW-1:0] C_LAST = CW'(CHANNELS - 1);

    if (IMG_SIZE % LANES != 0) begin : g_bad_lanes
        $error("IMG_SIZE must be a multiple of LANES");
    end
    if (FRAC_BITS >= DATA_WIDTH) begin : g_bad_frac
        $error("FRAC_BITS must be smaller than DATA_WIDTH");
    end

    act_state_t                    state_q, state_d;
    act_mode_t                     mode_q;
    logic signed [DATA_WIDTH-1:0]  clamp_q;
    logic [CW-1:0]                 c_q;
    logic [QW-1:0]                 r_q, q_q;
    logic                          busy_q, done_q;
    logic [NW-1:0]                 neg_q, neg_add;
    logic                          last_grp;

    logic [CHANNELS-1:0][IMG_SIZE-1:0][IMG_SIZE-1:0][DATA_WIDTH-1:0] out_q;

    logic [LANES-1:0][DATA_WIDTH-1:0] lane_in, lane_out;
    logic [LANES-1:0]                 lane_neg;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        localparam logic [QW-1:0] Q_OFF = QW'(l);
        assign lane_in[l] = in_feature[c_q][r_q][q_q + Q_OFF];
        act_lane #(
            .DATA_WIDTH  (DATA_WIDTH),
            .LEAKY_SHIFT (LEAKY_SHIFT)
        ) u_lane (
            .din_i    (lane_in[l]),
            .mode_i   (mode_q),
            .clamp_i  (clamp_q),
            .dout_o   (lane_out[l]),
            .is_neg_o (lane_neg[l])
        );
    end

    always_comb begin
        neg_add = '0;
        for (int l = 0; l < LANES; l++) neg_add = neg_add + NW'(lane_neg[l]);
    end

    assign last_grp = (q_q == Q_LAST) && (r_q == R_LAST) && (c_q == C_LAST);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_grp) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            neg_q   <= '0;
            c_q     <= '0;
            r_q     <= '0;
            q_q     <= '0;
            mode_q  <= ACT_PASS;
            clamp_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mode_q  <= act_mode_t'(mode);
                        clamp_q <= clamp_max;
                        c_q     <= '0;
                        r_q     <= '0;
                        q_q     <= '0;
                        neg_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    neg_q <= neg_q + neg_add;
                    if (q_q == Q_LAST) begin
                        q_q <= '0;
                        if (r_q == R_LAST) begin
                            r_q <= '0;
                            c_q <= last_grp ? '0 : c_q + CW'(1);
                        end else begin
                            r_q <= r_q + QW'(1);
                        end
                    end else begin
                        q_q <= q_q + Q_STEP;
                    end
                end
                FINISH: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Result map keeps whatever was written, even across a reset.
    always_ff @(posedge clk) begin
        if (!reset && state_q == RUN) begin
            for (int l = 0; l < LANES; l++)
                out_q[c_q][r_q][q_q + QW'(l)] <= lane_out[l];
        end
    end

    assign out_feature = out_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign neg_count   = neg_q;

endmodule

// File: tb/tb_activation_unit.sv
module tb_activation_unit;
    import act_pkg::*;

    localparam int DW  = 16;
    localparam int CH  = 2;
    localparam int IMG = 4;
    localparam int LN  = 2;
    localparam int NW  = $clog2(CH*IMG*IMG+1);

    typedef logic [CH-1:0][IMG-1:0][IMG-1:0][DW-1:0] map_t;
    typedef struct packed {
        map_t          m;
        logic [NW-1:0] n;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [DW-1:0] clamp_max = '0;
    map_t          in_feature = '0;
    map_t          out_feature;
    logic          busy, done;
    logic [NW-1:0] neg_count;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;

    activation_unit #(
        .DATA_WIDTH (DW), .FRAC_BITS (7), .CHANNELS (CH),
        .IMG_SIZE (IMG), .LANES (LN), .LEAKY_SHIFT (3)
    ) dut (
        .clk (clk), .reset (reset), .start (start), .mode (mode),
        .clamp_max (clamp_max), .in_feature (in_feature),
        .out_feature (out_feature), .busy (busy), .done (done),
        .neg_count (neg_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input longint got, input longint want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    // Monitor: each done pulse retires the oldest expected result.
    always @(negedge clk) begin : mon
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++; errors++;
                $display("FAIL unexpected_done: got done=1 want no pending run");
            end else begin
                e = sb.pop_front();
                vectors++;
                if (out_feature !== e.m) begin
                    errors++;
                    $display("FAIL out_map: got %h want %h", out_feature, e.m);
                end
                vectors++;
                if (neg_count !== e.n) begin
                    errors++;
                    $display("FAIL neg_count: got %0d want %0d", neg_count, e.n);
                end
            end
        end
    end

    function automatic map_t tile(input logic [DW-1:0] p0, input logic [DW-1:0] p1,
                                  input logic [DW-1:0] p2, input logic [DW-1:0] p3);
        map_t m;
        logic [DW-1:0] p [4];
        p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < IMG; r++)
                for (int x = 0; x < IMG; x++)
                    m[c][r][x] = p[x];
        return m;
    endfunction

    function automatic map_t ramp();
        map_t m;
        int   k;
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < IMG; r++)
                for (int x = 0; x < IMG; x++) begin
                    k = (c*IMG + r)*IMG + x;
                    m[c][r][x] = DW'(k*37 - 500);
                end
        return m;
    endfunction

    // Called on a falling edge with the DUT idle.
    task automatic launch(input logic [1:0] md, input logic [DW-1:0] cl,
                          input map_t in_m, input map_t ex_m, input int neg);
        mode       = md;
        clamp_max  = cl;
        in_feature = in_m;
        start      = 1'b1;
        sb.push_back('{m: ex_m, n: NW'(neg)});
    endtask

    // kind: 0 none, 1 toggle mode/clamp at j, 2 stray start at j,
    //       3 reset at j, 4 restart in the done cycle with n* arguments.
    task automatic track(input string nm, input int kind, input int at,
                         input logic [1:0] nmd, input logic [DW-1:0] ncl,
                         input map_t nin, input map_t nex, input int nneg);
        int busy_cnt;
        int done_at;
        int late_done;
        busy_cnt = 0;
        done_at  = -1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < 40; j++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_at = j;
                break;
            end
            start = (kind == 2 && j == at);
            if (kind == 1 && j == at) begin
                mode      = mode ^ 2'b11;
                clamp_max = ~clamp_max;
            end
            if (kind == 3 && j == at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check({nm, "_rst_busy"}, busy, 0);
                check({nm, "_rst_done"}, done, 0);
                check({nm, "_rst_neg"}, neg_count, 0);
                void'(sb.pop_back());
                late_done = 0;
                repeat (25) begin
                    @(negedge clk);
                    if (done === 1'b1) late_done++;
                end
                check({nm, "_no_done"}, late_done, 0);
                return;
            end
            @(negedge clk);
        end
        check({nm, "_busy_cycles"}, busy_cnt, 17);
        check({nm, "_done_edge"}, done_at, 17);
        if (kind == 4) begin
            launch(nmd, ncl, nin, nex, nneg);
        end else begin
            @(negedge clk);
            check({nm, "_done_fall"}, done, 0);
        end
    endtask

    map_t m0 = '0;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_neg", neg_count, 0);
        reset = 1'b0;
        @(negedge clk);

        launch(ACT_RELU, '0, tile(-16'sd5, 16'sd0, 16'sd7, -16'sd32768),
               tile(16'sd0, 16'sd0, 16'sd7, 16'sd0), 16);
        track("relu", 0, -1, 2'd0, '0, m0, m0, 0);

        launch(ACT_LEAKY, '0, tile(-16'sd40, -16'sd3, -16'sd32768, 16'sd100),
               tile(-16'sd5, -16'sd1, -16'sd4096, 16'sd100), 24);
        track("leaky", 0, -1, 2'd0, '0, m0, m0, 0);

        launch(ACT_CLIP, 16'sd768, tile(16'sd1000, 16'sd768, 16'sd500, -16'sd5),
               tile(16'sd768, 16'sd768, 16'sd500, 16'sd0), 8);
        track("clip", 0, -1, 2'd0, '0, m0, m0, 0);

        launch(ACT_CLIP, -16'sd1, tile(16'sd1000, 16'sd768, 16'sd500, -16'sd5),
               '0, 8);
        track("clip_neg", 0, -1, 2'd0, '0, m0, m0, 0);

        launch(ACT_PASS, 16'sd100, ramp(), ramp(), 14);
        track("pass_toggle", 1, 4, 2'd0, '0, m0, m0, 0);

        launch(ACT_RELU, '0, tile(-16'sd5, 16'sd0, 16'sd7, -16'sd32768),
               tile(16'sd0, 16'sd0, 16'sd7, 16'sd0), 16);
        track("stray_start", 2, 5, 2'd0, '0, m0, m0, 0);

        launch(ACT_LEAKY, '0, tile(-16'sd40, -16'sd3, -16'sd32768, 16'sd100),
               tile(-16'sd5, -16'sd1, -16'sd4096, 16'sd100), 24);
        track("chain_a", 4, -1, ACT_RELU, '0,
              tile(-16'sd5, 16'sd0, 16'sd7, -16'sd32768),
              tile(16'sd0, 16'sd0, 16'sd7, 16'sd0), 16);
        track("chain_b", 0, -1, 2'd0, '0, m0, m0, 0);

        launch(ACT_CLIP, 16'sd768, tile(16'sd1000, 16'sd768, 16'sd500, -16'sd5),
               tile(16'sd768, 16'sd768, 16'sd500, 16'sd0), 8);
        track("abort", 3, 8, 2'd0, '0, m0, m0, 0);

        launch(ACT_CLIP, 16'sd768, tile(16'sd1000, 16'sd768, 16'sd500, -16'sd5),
               tile(16'sd768, 16'sd768, 16'sd500, 16'sd0), 8);
        track("after_abort", 0, -1, 2'd0, '0, m0, m0, 0);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
